// File: rtl/axis_flit_generator.sv
// AXI-Stream packet source: turns a byte-length command into a packet with
// low-aligned tkeep, correct tlast and an incrementing-byte payload.
//
// Ports:
//   clk, aresetn        clock, asynchronous active-low reset
//   cmd_valid/ready/len length command handshake (bytes)
//   m_axis_*            AXI-Stream master (tdata/tkeep/tlast/tvalid/tready)
//   err_zero_len        one-cycle pulse when a zero-length command is dropped
//   pkts_sent           completed packets, wraps modulo 2^32
//   bytes_sent          transmitted bytes, wraps modulo 2^32
module axis_flit_generator #(
    parameter int TDATA_WIDTH = 128,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   err_zero_len,
    output logic [31:0]            pkts_sent,
    output logic [31:0]            bytes_sent
);

    localparam int BPB = TKEEP_WIDTH;
    localparam logic [LEN_WIDTH-1:0] BPB_L = LEN_WIDTH'(BPB);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_rem;
    logic [LEN_WIDTH-1:0]   w_rem_nxt;
    logic [LEN_WIDTH-1:0]   w_take;
    logic [7:0]             r_idx;
    logic [7:0]             w_idx_nxt;
    logic                   w_accept;
    logic                   w_hs;
    logic                   w_zero;
    logic                   w_send_nxt;
    logic [TKEEP_WIDTH-1:0] w_keep_nxt;
    logic [TDATA_WIDTH-1:0] w_data_nxt;
    logic                   w_last_nxt;

    logic                   r_cmd_ready;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [TKEEP_WIDTH-1:0] r_tkeep;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_err;
    logic [31:0]            r_pkts;
    logic [31:0]            r_bytes;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_idx_nxt   = r_idx;
        w_zero      = 1'b0;
        w_accept    = cmd_valid && r_cmd_ready;
        w_hs        = r_tvalid && m_axis_tready;
        w_take      = (r_rem < BPB_L) ? r_rem : BPB_L;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_len == '0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_state_nxt = SEND;
                        w_rem_nxt   = cmd_len;
                        w_idx_nxt   = 8'd0;
                    end
                end
            end
            SEND: begin
                if (w_hs) begin
                    w_rem_nxt = r_rem - w_take;
                    w_idx_nxt = r_idx + 8'(BPB);
                    if (r_tlast) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Beat outputs are built from the next-cycle state so they can be
        // registered; a stall leaves rem/idx untouched, so the beat holds.
        w_send_nxt = (w_state_nxt == SEND);
        w_keep_nxt = '0;
        w_data_nxt = '0;
        for (int j = 0; j < BPB; j++) begin
            w_keep_nxt[j] = w_send_nxt && (w_rem_nxt > LEN_WIDTH'(j));
            if (w_send_nxt) begin
                w_data_nxt[8*j +: 8] = w_idx_nxt + 8'(j);
            end
        end
        w_last_nxt = w_send_nxt && (w_rem_nxt <= BPB_L);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_idx       <= '0;
            r_cmd_ready <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tkeep     <= '0;
            r_tdata     <= '0;
            r_err       <= 1'b0;
            r_pkts      <= '0;
            r_bytes     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_idx       <= w_idx_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_tvalid    <= w_send_nxt;
            r_tlast     <= w_last_nxt;
            r_tkeep     <= w_keep_nxt;
            r_tdata     <= w_data_nxt;
            r_err       <= w_zero;
            if (w_hs) begin
                r_bytes <= r_bytes + 32'(w_take);
                if (r_tlast) begin
                    r_pkts <= r_pkts + 32'd1;
                end
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tdata  = r_tdata;
    assign err_zero_len  = r_err;
    assign pkts_sent     = r_pkts;
    assign bytes_sent    = r_bytes;

endmodule
